// File: rtl/state_dump_pkg.sv
// state_dump_pkg: shared FSM state, dump kind and halt cause encodings
package state_dump_pkg;
  typedef enum logic [2:0] {RUN, HALT, DUMP_CYC, DUMP_REG, DUMP_MEM, DONE} state_t;
  localparam logic [1:0] KIND_CYC = 2'd0;
  localparam logic [1:0] KIND_REG = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_INST = 2'd1;
  localparam logic [1:0] CAUSE_STOP = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;
  function automatic logic [1:0] kind_of(input state_t s);
    return s == DUMP_REG ? KIND_REG : s == DUMP_MEM ? KIND_MEM : KIND_CYC;
  endfunction
endpackage

// File: rtl/state_dump_cycle_counter.sv
// state_dump_cycle_counter: run-cycle counter with freeze and timeout terminal count
module state_dump_cycle_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        freeze,
  output logic [31:0] count,
  output logic        tc
);
  assign tc = count == 32'(TIMEOUT - 1);
  // count run cycles; the halting cycle itself is not counted so the dump shows its index
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (en && !freeze) count <= count + 32'd1;
endmodule

// File: rtl/state_dump_ctrl.sv
// state_dump_ctrl: halts a run and streams cycle count, registers and memory; STATE_DUMP_MEM_EN enables the memory phase
module state_dump_ctrl
  import state_dump_pkg::*;
#(
  parameter int          NREGS     = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] MEM_BASE  = 32'h4000,
  parameter int          MEM_WORDS = 4,
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] HALT_INST = 32'h00000000,
  localparam int         AW        = NREGS > 1 ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inst,
  input  logic              inst_valid,
  input  logic              stop,
  output logic [AW-1:0]     reg_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [1:0]        dump_kind,
  output logic              halted,
  output logic              done,
  output logic [1:0]        halt_cause
);
  state_t state, nxt;
  logic [31:0] count;
  logic tc, hit_inst, halt_req, fire, last_reg, last_mem;
  assign hit_inst = inst_valid && inst == HALT_INST;
  assign halt_req = state == RUN && (hit_inst || stop || tc);
  assign fire     = dump_valid && dump_ready;
  assign last_reg = reg_addr == AW'(NREGS - 1);
  assign last_mem = mem_addr == MEM_BASE + 32'(MEM_WORDS - 1);

  state_dump_cycle_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk(clk), .reset(reset), .en(state == RUN), .freeze(halt_req), .count(count), .tc(tc)
  );

  // next state: each dump phase hands over on the accept of its last beat
  always_comb begin
    nxt = state;
    case (state)
      RUN:      nxt = halt_req ? HALT : RUN;
      HALT:     nxt = DUMP_CYC;
      DUMP_CYC: nxt = fire ? DUMP_REG : DUMP_CYC;
`ifdef STATE_DUMP_MEM_EN
      DUMP_REG: nxt = fire && last_reg ? DUMP_MEM : DUMP_REG;
`else
      DUMP_REG: nxt = fire && last_reg ? DONE : DUMP_REG;
`endif
      DUMP_MEM: nxt = fire && last_mem ? DONE : DUMP_MEM;
      default:  nxt = state;
    endcase
  end

  // state plus outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= RUN;
      halt_cause <= CAUSE_NONE;
      halted     <= 1'b0;
      done       <= 1'b0;
      dump_valid <= 1'b0;
      dump_kind  <= KIND_CYC;
      reg_addr   <= '0;
    end else begin
      state      <= nxt;
      if (halt_req) halt_cause <= hit_inst ? CAUSE_INST : stop ? CAUSE_STOP : CAUSE_TIMEOUT;
      halted     <= nxt != RUN;
      done       <= nxt == DONE;
      dump_valid <= nxt inside {DUMP_CYC, DUMP_REG, DUMP_MEM};
      dump_kind  <= kind_of(nxt);
      if (state == DUMP_REG && fire) reg_addr <= last_reg ? '0 : reg_addr + AW'(1);
    end

`ifdef STATE_DUMP_MEM_EN
  // memory word index walks the window and parks at the base outside the phase
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem_addr <= MEM_BASE;
    else if (state == DUMP_MEM && fire) mem_addr <= last_mem ? MEM_BASE : mem_addr + 32'd1;
`else
  assign mem_addr = MEM_BASE;
`endif

  // beat payload follows the phase; read data is combinational from the addressed entry
  always_comb
    dump_data = state == DUMP_CYC ? DATA_W'(count) :
                state == DUMP_REG ? reg_rdata :
                state == DUMP_MEM ? mem_rdata : '0;
endmodule

// File: tb/tb_state_dump_ctrl.sv
// tb_state_dump_ctrl: directed vector bench for state_dump_ctrl
module tb_state_dump_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst = 32'h13;
  logic        inst_valid = 1'b1;
  logic        stop = 1'b0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic        dump_ready = 1'b1;
  logic [31:0] dump_data;
  logic [1:0]  dump_kind;
  logic        halted;
  logic        done;
  logic [1:0]  halt_cause;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          at;
    logic        iv;
    logic [31:0] iw;
    logic        st;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } vec_t;
  vec_t vec[9];

  function automatic logic [31:0] reg_model(input logic [4:0] i);
    return i == 5'd11 ? 32'd123 : 32'hA000_0000 | 32'(i);
  endfunction

  assign reg_rdata = reg_model(reg_addr);
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

  state_dump_ctrl dut (
    .clk(clk), .reset(reset), .inst(inst), .inst_valid(inst_valid), .stop(stop),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_kind(dump_kind),
    .halted(halted), .done(done), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    inst = 32'h13;
    inst_valid = 1'b1;
    stop = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_halted", halted, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_kind", dump_kind, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_mem_addr", mem_addr, 32'h4000);
    chk("rst_cause", halt_cause, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    dump_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
  endtask

  // called at a negedge in DUMP_CYC; halt inputs are held active to show they are ignored
  task automatic drain(input logic [31:0] cnt, input logic [1:0] cause);
    inst = 32'h0;
    inst_valid = 1'b1;
    stop = 1'b1;
    dump_ready = 1'b1;
    chk("cyc_valid", dump_valid, 1);
    chk("cyc_kind", dump_kind, 0);
    chk("cyc_data", dump_data, cnt);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      chk("reg_valid", dump_valid, 1);
      chk("reg_kind", dump_kind, 1);
      chk("reg_addr", reg_addr, i);
      chk("reg_data", dump_data, reg_model(5'(i)));
      chk("reg_mem_idle", mem_addr, 32'h4000);
      @(negedge clk);
    end
`ifdef STATE_DUMP_MEM_EN
    for (int j = 0; j < 4; j++) begin
      chk("mem_valid", dump_valid, 1);
      chk("mem_kind", dump_kind, 2);
      chk("mem_addr", mem_addr, 32'h4000 + j);
      chk("mem_data", dump_data, (32'h4000 + j) ^ 32'h5A5A_0000);
      chk("mem_reg_idle", reg_addr, 0);
      @(negedge clk);
    end
`endif
    chk("end_done", done, 1);
    chk("end_valid", dump_valid, 0);
    chk("end_halted", halted, 1);
    chk("end_cause", halt_cause, cause);
  endtask

  // starts in run cycle 0 at a negedge; at<0 means no event is driven
  task automatic run_vec(input int at, input logic iv, input logic [31:0] iw, input logic st,
                         input logic [1:0] cause, input logic [31:0] cnt);
    int c;
    c = 0;
    for (int k = 0; k < 100 && !halted; k++) begin
      inst = k == at ? iw : 32'h13;
      inst_valid = k == at ? iv : 1'b1;
      stop = k == at && st;
      @(negedge clk);
      c++;
    end
    idle();
    chk("halt_cycle", c, cnt + 1);
    chk("halt_halted", halted, 1);
    chk("halt_cause", halt_cause, cause);
    chk("halt_valid", dump_valid, 0);
    chk("halt_done", done, 0);
    @(negedge clk);
    drain(cnt, cause);
  endtask

  initial begin
    vec[0] = '{5,  1'b1, 32'h0,  1'b0, 2'd1, 32'd5};
    vec[1] = '{9,  1'b1, 32'h13, 1'b1, 2'd2, 32'd9};
    vec[2] = '{3,  1'b1, 32'h0,  1'b1, 2'd1, 32'd3};
    vec[3] = '{-1, 1'b0, 32'h13, 1'b0, 2'd3, 32'd63};
    vec[4] = '{5,  1'b0, 32'h0,  1'b0, 2'd3, 32'd63};
    vec[5] = '{0,  1'b1, 32'h13, 1'b1, 2'd2, 32'd0};
    vec[6] = '{62, 1'b0, 32'h0,  1'b1, 2'd2, 32'd62};
    vec[7] = '{63, 1'b1, 32'h0,  1'b0, 2'd1, 32'd63};
    vec[8] = '{63, 1'b0, 32'h13, 1'b1, 2'd2, 32'd63};
    for (int v = 0; v < 9; v++) begin
      do_reset();
      run_vec(vec[v].at, vec[v].iv, vec[v].iw, vec[v].st, vec[v].cause, vec[v].cnt);
    end
    // backpressure on register 11, then reset with register 12 pending
    do_reset();
    repeat (2) @(negedge clk);
    inst = 32'h0;
    @(negedge clk);
    idle();
    chk("bp_halted", halted, 1);
    @(negedge clk);
    chk("bp_cyc_data", dump_data, 2);
    repeat (12) @(negedge clk);
    chk("bp_at11", reg_addr, 11);
    dump_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      chk("bp_hold_addr", reg_addr, 11);
      chk("bp_hold_data", dump_data, 123);
      chk("bp_hold_valid", dump_valid, 1);
      chk("bp_hold_kind", dump_kind, 1);
      @(negedge clk);
    end
    chk("bp_still11", reg_addr, 11);
    dump_ready = 1'b1;
    @(negedge clk);
    chk("bp_one_accept", reg_addr, 12);
    dump_ready = 1'b0;
    @(negedge clk);
    chk("bp_pending12", reg_addr, 12);
    chk("bp_pending_valid", dump_valid, 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals();
    idle();
    dump_ready = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    run_vec(7, 1'b0, 32'h13, 1'b1, 2'd2, 32'd7);
    // DONE is sticky whatever the inputs do
    for (int d = 0; d < 5; d++) begin
      dump_ready = d[0];
      stop = ~d[0];
      inst = 32'h0;
      @(negedge clk);
      chk("sticky_done", done, 1);
      chk("sticky_valid", dump_valid, 0);
      chk("sticky_cause", halt_cause, 2);
      chk("sticky_reg_addr", reg_addr, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/state_dump_ctrl.md
STATE_DUMP_CTRL -- requirements
Module: state_dump_ctrl

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of register-file entries dumped.
REQ-002 SHALL have parameter DATA_W, default 32, width of the register and memory read data and of dump_data.
REQ-003 SHALL have parameter MEM_BASE, default 32'h4000, first memory word index dumped.
REQ-004 SHALL have parameter MEM_WORDS, default 4, number of memory words dumped.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum run cycles before a forced halt.
REQ-006 SHALL have parameter HALT_INST, default 32'h00000000, instruction encoding that halts.
REQ-007 SHALL have the ports below, clock and reset first:
- clk  in  1  clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  32  instruction currently executing.
- inst_valid  in  1  inst is meaningful this cycle.
- stop  in  1  external halt request.
- reg_addr  out  $clog2(NREGS)  register read index.
- reg_rdata  in  DATA_W  combinational register read data.
- mem_addr  out  32  memory word index.
- mem_rdata  in  DATA_W  combinational memory read data.
- dump_valid  out  1  dump beat offered.
- dump_ready  in  1  dump beat accepted.
- dump_data  out  DATA_W  beat payload.
- dump_kind  out  2  0=cycle count, 1=register, 2=memory.
- halted  out  1  the run has ended.
- done  out  1  dump complete, sticky.
- halt_cause  out  2  0=none, 1=halt instruction, 2=stop, 3=timeout.

Function
REQ-008 SHALL implement the states RUN, HALT, DUMP_CYC, DUMP_REG, DUMP_MEM and DONE.
REQ-009 SHALL increment a 32-bit cycle counter every RUN cycle, starting from 0 after reset release.
REQ-010 SHALL leave RUN for HALT when, in a RUN cycle, any of these holds:
- inst_valid and inst==HALT_INST;
- stop is high;
- the cycle counter equals TIMEOUT-1.
REQ-011 SHALL pick halt_cause by priority when halt conditions coincide: halt instruction > stop > timeout.
REQ-012 SHALL latch halt_cause in the HALT cycle, stop the counter there, and assert halted from HALT onward.
REQ-013 SHALL spend exactly one cycle in HALT, then enter DUMP_CYC.
- DUMP_CYC offers one beat: dump_kind=0, dump_data = frozen count, zero-extended or truncated to DATA_W.
REQ-014 SHALL, in DUMP_REG, offer beats with index i=0..NREGS-1, one per beat:
- reg_addr=i, dump_kind=1, dump_data=reg_rdata;
- the index advances only on dump_valid && dump_ready.
REQ-015 SHALL, in DUMP_MEM, offer beats for MEM_BASE..MEM_BASE+MEM_WORDS-1:
- mem_addr = current word index, dump_kind=2, dump_data=mem_rdata;
- the same advance rule as DUMP_REG applies.
REQ-016 SHALL hold reg_addr, mem_addr, dump_kind and dump_valid stable while dump_valid && !dump_ready.
REQ-017 SHALL keep dump_valid high in every DUMP_* cycle and low in all other states.
REQ-018 SHALL move on from the last beat of each phase in the same cycle it is accepted, with no bubble before the next phase.
REQ-019 SHALL, in DONE, hold done=1 and dump_valid=0, ignore all inputs and stay there until reset.
REQ-020 SHALL ignore inst, inst_valid and stop outside RUN.
REQ-021 SHALL drive reg_addr=0 and mem_addr=MEM_BASE when not in DUMP_REG or DUMP_MEM respectively.

Reset
REQ-022 SHALL, on reset low at any time (including mid-dump with a beat pending), asynchronously force:
- state RUN, counter 0, halt_cause 0;
- halted=0, done=0, dump_valid=0;
- dump_data=0, dump_kind=0, reg_addr=0, mem_addr=MEM_BASE.
REQ-023 SHALL resume counting on the first rising clk edge after reset deasserts.

Configuration
REQ-024 SHALL use macro STATE_DUMP_MEM_EN to control the memory phase:
- defined: DUMP_MEM exists and follows DUMP_REG;
- undefined: DUMP_REG goes directly to DONE, mem_addr is tied to MEM_BASE and mem_rdata is unused.

Structure
REQ-025 SHALL take the state enum, dump_kind codes and halt_cause codes from shared package state_dump_pkg.
REQ-026 SHALL place the run/timeout counter in one sub-module, state_dump_cycle_counter, with enable, freeze and terminal-count outputs.

Verification
REQ-027 SHALL cover halt instruction: inst=0 valid at cycle 5, dump_ready=1 -> halt_cause=1, cycle beat 5, 32 register beats, 4 memory beats 0x4000..0x4003, then done.
REQ-028 SHALL cover timeout: TIMEOUT=64, no halt or stop -> halt_cause=3, cycle beat 63.
REQ-029 SHALL cover simultaneous events: stop=1 and inst=0 valid in the same cycle -> halt_cause=1.
REQ-030 SHALL cover backpressure: dump_ready low for 3 cycles on register 11, whose value is 123 -> reg_addr=11 and dump_data=123 held for all 3 cycles, then exactly one accepted beat.
REQ-031 SHALL cover reset during dump: reset low while DUMP_REG has i=12 -> all outputs at reset values within the same cycle, counter restarts from 0.
REQ-032 SHALL cover the build without STATE_DUMP_MEM_EN -> done asserts the cycle after register 31 is accepted, and no beat has dump_kind=2.
